// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmitter peripheral: register offsets,
// CTRL/STATUS bit positions and the TX state encoding.
package uart_tx_dev_pkg;

  localparam logic [1:0] UART_REG_CTRL   = 2'd0;
  localparam logic [1:0] UART_REG_DIV    = 2'd1;
  localparam logic [1:0] UART_REG_DATA   = 2'd2;
  localparam logic [1:0] UART_REG_STATUS = 2'd3;

  localparam int unsigned CTRL_TX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  typedef enum logic [1:0] {
    UART_ST_IDLE  = 2'd0,
    UART_ST_START = 2'd1,
    UART_ST_DATA  = 2'd2,
    UART_ST_STOP  = 2'd3
  } uart_state_e;

  // A zero divider would stall the baud counter, so it is stored as 1.
  function automatic logic [15:0] div_sanitize(input logic [15:0] v);
    return (v == '0) ? 16'd1 : v;
  endfunction

endpackage

// File: rtl/uart_tx_dev_sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    count = count_q;
    full  = (count_q == CW'(DEPTH));
    empty = (count_q == '0);
  end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud
// counter, shift register and drained-queue level interrupt.
module uart_tx_dev
  import uart_tx_dev_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ,
  output logic        txd
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  uart_state_e   state_q, state_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   period_q, period_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          irq_q, irq_d;

  logic [1:0]    sel;
  logic          wr_ctrl, wr_div, wr_data, wr_status;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          start_ok, launch, baud_end;
  logic [31:0]   status;
  logic          unused_bits;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (wr_data),
    .pop   (fifo_pop),
    .wdata (Din[7:0]),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    unused_bits = ^{Addr[29:2], Din[31:16]};
    sel       = Addr[1:0];
    wr_ctrl   = WE && (sel == UART_REG_CTRL);
    wr_div    = WE && (sel == UART_REG_DIV);
    wr_data   = WE && (sel == UART_REG_DATA);
    wr_status = WE && (sel == UART_REG_STATUS);

    ctrl_d = ctrl_q;
    div_d  = div_q;
    ovf_d  = ovf_q;
    if (wr_ctrl)   ctrl_d = Din[1:0];
    if (wr_div)    div_d  = div_sanitize(Din[15:0]);
    if (wr_status) ovf_d  = 1'b0;
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;

    irq_d = ctrl_q[CTRL_IRQ_EN] && fifo_empty && (state_q == UART_ST_IDLE);
  end

  // One launch path serves both IDLE and the end of STOP, so back-to-back
  // frames reload the divider and pop without an idle cycle in between.
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    launch    = 1'b0;
    txd       = 1'b1;
    start_ok  = ctrl_q[CTRL_TX_EN] && !fifo_empty;
    baud_end  = (baud_q == '0);

    unique case (state_q)
      UART_ST_IDLE: begin
        launch = start_ok;
      end
      UART_ST_START: begin
        txd = 1'b0;
        if (baud_end) begin
          state_d   = UART_ST_DATA;
          bit_idx_d = '0;
          baud_d    = period_q - 16'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      UART_ST_DATA: begin
        txd = shift_q[0];
        if (baud_end) begin
          baud_d  = period_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = UART_ST_STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      UART_ST_STOP: begin
        if (baud_end) begin
          if (start_ok) launch = 1'b1;
          else state_d = UART_ST_IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
    endcase

    if (launch) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      period_d = div_q;
      baud_d   = div_q - 16'd1;
      state_d  = UART_ST_START;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= UART_ST_IDLE;
      ctrl_q    <= '0;
      div_q     <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      period_q  <= DEFAULT_DIV;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      period_q  <= period_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    status = '0;
    status[STAT_BUSY]  = (state_q != UART_ST_IDLE);
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = ovf_q;
    status[STAT_CNT_LSB +: 8] = {{(8-CW){1'b0}}, fifo_count};

    Dout = '0;
    if (reset) begin
      unique case (sel)
        UART_REG_CTRL:   Dout[1:0]  = ctrl_q;
        UART_REG_DIV:    Dout[15:0] = div_q;
        UART_REG_DATA:   Dout       = '0;
        UART_REG_STATUS: Dout       = status;
      endcase
    end
    IRQ = irq_q;
  end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev: bytes written to DATA go into a scoreboard
// queue and a line monitor decodes each frame and compares against it.
module tb_uart_tx_dev;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [29:0] Addr  = '0;
  logic        WE    = 1'b0;
  logic [31:0] Din   = '0;
  logic [31:0] Dout;
  logic        IRQ;
  logic        txd;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int frames  = 0;
  int mon_div = 16;
  logic [7:0] exp_q [$];
  int         start_cyc [$];

  uart_tx_dev #(
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ),
    .txd   (txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] v);
    Addr = {28'd0, a};
    Din  = v;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = {28'd0, a};
    #1 d = Dout;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    wr(2'd2, {24'd0, b});
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_frames", 32'(frames), 32'(target));
  endtask

  // Line monitor: samples every cycle of a frame, checks each bit is held
  // for the whole bit period and pops the scoreboard for the byte value.
  initial begin : monitor
    int         d;
    logic [7:0] rx;
    logic [7:0] expb;
    bit         shape_ok;
    bit         aborted;
    logic       lvl;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && txd === 1'b0) begin
        d = mon_div;
        rx = '0;
        shape_ok = 1'b1;
        aborted = 1'b0;
        start_cyc.push_back(cyc);
        for (int s = 0; s < 10 * d; s++) begin
          if (s > 0) @(negedge clk);
          if (reset !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          lvl = txd;
          if (s < d) begin
            if (lvl !== 1'b0) shape_ok = 1'b0;
          end else if (s >= 9 * d) begin
            if (lvl !== 1'b1) shape_ok = 1'b0;
          end else if ((s % d) == 0) begin
            rx[s / d - 1] = lvl;
          end else if (lvl !== rx[s / d - 1]) begin
            shape_ok = 1'b0;
          end
        end
        if (!aborted) begin
          check("frame_shape", 32'(shape_ok), 32'd1);
          checks++;
          assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL frame_unexpected: observed byte 0x%0h expected no frame", rx);
          end
          if (exp_q.size() > 0) begin
            expb = exp_q.pop_front();
            check("frame_byte", 32'(rx), 32'(expb));
          end
          frames++;
        end
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: observed no completion expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] r;
    bit          ok;
    int          f0;
    int          n0;

    // Reset state
    Addr = 30'd1;
    #2;
    check("rst_dout", Dout, 32'd0);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_irq", 32'(IRQ), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    rd(2'd0, r); check("ctrl_reset", r, 32'd0);
    rd(2'd1, r); check("div_reset", r, 32'd16);
    rd(2'd3, r); check("status_reset", r, 32'h004);

    // T1: DIV=4, single byte 0x55, busy across exactly 40 cycles
    wr(2'd1, 32'd4);
    mon_div = 4;
    wr(2'd0, 32'd1);
    rd(2'd1, r); check("div_readback", r, 32'd4);
    f0 = frames;
    push_byte(8'h55);
    Addr = 30'd3;
    #1 check("t1_count_after_write", {24'd0, Dout[15:8]}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 if (Dout[0] !== 1'b1) ok = 1'b0;
    end
    check("t1_busy_during", 32'(ok), 32'd1);
    @(negedge clk);
    #1 check("t1_busy_after", 32'(Dout[0]), 32'd0);
    wait_frames(f0 + 1, 100);

    // T2: fill while disabled, overflow on the ninth byte
    wr(2'd0, 32'd0);
    mon_div = 2;
    wr(2'd1, 32'd2);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'(i));
      wr(2'd2, 32'(i));
    end
    rd(2'd3, r); check("t2_status_full_ovf", r, 32'h80A);
    f0 = frames;
    wr(2'd0, 32'd1);
    wait_frames(f0 + 8, 400);
    repeat (3) @(negedge clk);
    rd(2'd3, r); check("t2_ovf_sticky", r, 32'h00C);
    wr(2'd3, 32'd0);
    rd(2'd3, r); check("t2_ovf_cleared", r, 32'h004);
    check("t2_irq_disabled", 32'(IRQ), 32'd0);

    // T3: back-to-back frames at DIV=2
    n0 = start_cyc.size();
    f0 = frames;
    push_byte(8'hA3);
    push_byte(8'h3C);
    wait_frames(f0 + 2, 200);
    if (start_cyc.size() >= n0 + 2)
      check("t3_frame_gap", 32'(start_cyc[n0 + 1] - start_cyc[n0]), 32'd20);
    repeat (3) @(negedge clk);
    #1 check("t3_txd_idle", 32'(txd), 32'd1);

    // T4: IRQ behaviour around a frame
    @(negedge clk);
    wr(2'd0, 32'd3);
    @(negedge clk);
    #1 check("t4_irq_idle", 32'(IRQ), 32'd1);
    @(negedge clk);
    f0 = frames;
    push_byte(8'hFF);
    #1 check("t4_irq_write_edge", 32'(IRQ), 32'd1);
    @(negedge clk);
    #1 check("t4_irq_fell", 32'(IRQ), 32'd0);
    repeat (20) @(negedge clk);
    #1 check("t4_irq_before_rise", 32'(IRQ), 32'd0);
    @(negedge clk);
    #1 check("t4_irq_rose", 32'(IRQ), 32'd1);
    @(negedge clk);
    wr(2'd0, 32'd1);
    @(negedge clk);
    push_byte(8'h5A);
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1 if (IRQ !== 1'b0) ok = 1'b0;
    end
    check("t4_irq_masked", 32'(ok), 32'd1);
    wait_frames(f0 + 2, 100);
    repeat (3) @(negedge clk);

    // T5: DIV=0 stored as 1, ten-cycle frame
    wr(2'd1, 32'd0);
    rd(2'd1, r); check("t5_div_zero_reads_1", r, 32'd1);
    mon_div = 1;
    f0 = frames;
    push_byte(8'h81);
    wait_frames(f0 + 1, 50);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // T6: asynchronous reset in the middle of a data bit
    wr(2'd1, 32'd4);
    mon_div = 4;
    push_byte(8'h00);
    push_byte(8'h00);
    Addr = 30'd1;
    repeat (4) @(negedge clk);
    #2 check("t6_mid_data_bit", 32'(txd), 32'd0);
    reset = 1'b0;
    #1;
    check("t6_rst_txd", 32'(txd), 32'd1);
    check("t6_rst_irq", 32'(IRQ), 32'd0);
    check("t6_rst_dout", Dout, 32'd0);
    exp_q.delete();
    f0 = frames;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    rd(2'd1, r); check("t6_div_default", r, 32'd16);
    rd(2'd0, r); check("t6_ctrl_cleared", r, 32'd0);
    rd(2'd3, r); check("t6_status_empty", r, 32'h004);
    wr(2'd0, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1 if (txd !== 1'b1) ok = 1'b0;
    end
    check("t6_line_quiet", 32'(ok), 32'd1);
    check("t6_no_frames", 32'(frames), 32'(f0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
